// File: rtl/alu_exec_queue.sv
// Integer execution unit: in-order issue queue feeding a single-cycle ALU/branch
// evaluator whose result is held in an output register until the CDB grants it.
module alu_exec_queue #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int OP_W  = 6,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [OP_W-1:0]          in_op,
    input  logic [XLEN-1:0]          in_imm,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic [XLEN-1:0]          in_rs1,
    input  logic [XLEN-1:0]          in_rs2,
    input  logic                     in_pred_taken,
    output logic                     out_valid,
    input  logic                     cdb_grant,
    output logic [TAG_W-1:0]         out_tag,
    output logic [XLEN-1:0]          out_data,
    output logic                     out_taken,
    output logic [XLEN-1:0]          out_target,
    output logic                     out_mispred,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [OP_W-1:0] OP_LUI  = 'd0,  OP_AUIPC = 'd1,  OP_JAL   = 'd2,  OP_JALR  = 'd3;
    localparam logic [OP_W-1:0] OP_BEQ  = 'd4,  OP_BNE   = 'd5,  OP_BLT   = 'd6,  OP_BGE   = 'd7;
    localparam logic [OP_W-1:0] OP_BLTU = 'd8,  OP_BGEU  = 'd9,  OP_ADDI  = 'd10, OP_SLTI  = 'd11;
    localparam logic [OP_W-1:0] OP_SLTIU= 'd12, OP_XORI  = 'd13, OP_ORI   = 'd14, OP_ANDI  = 'd15;
    localparam logic [OP_W-1:0] OP_SLLI = 'd16, OP_SRLI  = 'd17, OP_SRAI  = 'd18, OP_ADD   = 'd19;
    localparam logic [OP_W-1:0] OP_SUB  = 'd20, OP_SLL   = 'd21, OP_SLT   = 'd22, OP_SLTU  = 'd23;
    localparam logic [OP_W-1:0] OP_XOR  = 'd24, OP_SRL   = 'd25, OP_SRA   = 'd26, OP_OR    = 'd27;
    localparam logic [OP_W-1:0] OP_AND  = 'd28;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [OP_W-1:0]  op;
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  rs1;
        logic [XLEN-1:0]  rs2;
        logic             pred;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_out_valid, r_out_taken, r_out_mispred;
    logic [TAG_W-1:0] r_out_tag;
    logic [XLEN-1:0] r_out_data, r_out_target;

    entry_t          w_head;
    logic            w_accept, w_pop, w_is_br, w_taken;
    logic [XLEN-1:0] w_data, w_target, w_pc4, w_pcimm, w_jalr_sum, w_one;

    assign in_ready = (r_count < CW'(DEPTH));
    assign w_accept = in_valid & in_ready & rdy & ~flush;
    assign w_pop    = (r_count != '0) & (~r_out_valid | cdb_grant) & rdy & ~flush;
    assign w_head   = r_mem[r_rd_ptr];

    assign w_pc4      = w_head.pc + XLEN'(4);
    assign w_pcimm    = w_head.pc + w_head.imm;
    assign w_jalr_sum = w_head.rs1 + w_head.imm;
    assign w_one      = XLEN'(1);

    always_comb begin
        w_data  = '0;
        w_taken = 1'b0;
        w_is_br = 1'b0;
        case (w_head.op)
            OP_LUI:   w_data = w_head.imm;
            OP_AUIPC: w_data = w_pcimm;
            OP_JAL, OP_JALR: begin
                w_data  = w_pc4;
                w_taken = 1'b1;
            end
            OP_BEQ:   begin w_is_br = 1'b1; w_taken = (w_head.rs1 == w_head.rs2); end
            OP_BNE:   begin w_is_br = 1'b1; w_taken = (w_head.rs1 != w_head.rs2); end
            OP_BLT:   begin w_is_br = 1'b1; w_taken = ($signed(w_head.rs1) <  $signed(w_head.rs2)); end
            OP_BGE:   begin w_is_br = 1'b1; w_taken = ($signed(w_head.rs1) >= $signed(w_head.rs2)); end
            OP_BLTU:  begin w_is_br = 1'b1; w_taken = (w_head.rs1 <  w_head.rs2); end
            OP_BGEU:  begin w_is_br = 1'b1; w_taken = (w_head.rs1 >= w_head.rs2); end
            OP_ADDI:  w_data = w_head.rs1 + w_head.imm;
            OP_SLTI:  w_data = {{(XLEN-1){1'b0}}, $signed(w_head.rs1) < $signed(w_head.imm)};
            OP_SLTIU: w_data = {{(XLEN-1){1'b0}}, w_head.rs1 < w_head.imm};
            OP_XORI:  w_data = w_head.rs1 ^ w_head.imm;
            OP_ORI:   w_data = w_head.rs1 | w_head.imm;
            OP_ANDI:  w_data = w_head.rs1 & w_head.imm;
            OP_SLLI:  w_data = w_head.rs1 << w_head.imm[4:0];
            OP_SRLI:  w_data = w_head.rs1 >> w_head.imm[4:0];
            OP_SRAI:  w_data = $signed(w_head.rs1) >>> w_head.imm[4:0];
            OP_ADD:   w_data = w_head.rs1 + w_head.rs2;
            OP_SUB:   w_data = w_head.rs1 - w_head.rs2;
            OP_SLL:   w_data = w_head.rs1 << w_head.rs2[4:0];
            OP_SLT:   w_data = {{(XLEN-1){1'b0}}, $signed(w_head.rs1) < $signed(w_head.rs2)};
            OP_SLTU:  w_data = {{(XLEN-1){1'b0}}, w_head.rs1 < w_head.rs2};
            OP_XOR:   w_data = w_head.rs1 ^ w_head.rs2;
            OP_SRL:   w_data = w_head.rs1 >> w_head.rs2[4:0];
            OP_SRA:   w_data = $signed(w_head.rs1) >>> w_head.rs2[4:0];
            OP_OR:    w_data = w_head.rs1 | w_head.rs2;
            OP_AND:   w_data = w_head.rs1 & w_head.rs2;
            default:  w_data = '0;
        endcase
    end

    // Not-taken branches, ALU ops and unknown opcodes all fall through to pc+4.
    always_comb begin
        w_target = w_pc4;
        if (w_head.op == OP_JAL)
            w_target = w_pcimm;
        else if (w_head.op == OP_JALR)
            w_target = w_jalr_sum & ~w_one;
        else if (w_is_br && w_taken)
            w_target = w_pcimm;
    end

    always_ff @(posedge clk) begin
        if (!rst && w_accept)
            r_mem[r_wr_ptr] <= '{pc: in_pc, op: in_op, imm: in_imm, tag: in_tag,
                                 rs1: in_rs1, rs2: in_rs2, pred: in_pred_taken};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_out_valid   <= 1'b0;
            r_out_tag     <= '0;
            r_out_data    <= '0;
            r_out_taken   <= 1'b0;
            r_out_target  <= '0;
            r_out_mispred <= 1'b0;
        end else if (rdy) begin
            if (flush) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
                r_out_valid <= 1'b0;
            end else begin
                if (w_accept)
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop) begin
                    r_rd_ptr      <= r_rd_ptr + PW'(1);
                    r_out_valid   <= 1'b1;
                    r_out_tag     <= w_head.tag;
                    r_out_data    <= w_data;
                    r_out_taken   <= w_taken;
                    r_out_target  <= w_target;
                    r_out_mispred <= w_taken ^ w_head.pred;
                end else if (cdb_grant) begin
                    r_out_valid <= 1'b0;
                end
                case ({w_accept, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_tag     = r_out_tag;
    assign out_data    = r_out_data;
    assign out_taken   = r_out_taken;
    assign out_target  = r_out_target;
    assign out_mispred = r_out_mispred;
    assign count       = r_count;
endmodule

// File: tb/tb_alu_exec_queue.sv
// Bench for alu_exec_queue: directed literal cases plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_alu_exec_queue;
    localparam int XLEN = 32, TAG_W = 4, OP_W = 6, DEPTH = 4;

    localparam logic [5:0] LUI = 0, AUIPC = 1, JAL = 2, JALR = 3, BEQ = 4, BNE = 5, BLT = 6, BGE = 7;
    localparam logic [5:0] BLTU = 8, BGEU = 9, ADDI = 10, SLTI = 11, SLTIU = 12, XORI = 13, ORI = 14;
    localparam logic [5:0] ANDI = 15, SLLI = 16, SRLI = 17, SRAI = 18, ADD = 19, SUB = 20, SLL = 21;
    localparam logic [5:0] SLT = 22, SLTU = 23, XOR_ = 24, SRL = 25, SRA = 26, OR_ = 27, AND_ = 28;

    logic clk = 0;
    logic rst, rdy, flush, in_valid, in_ready, in_pred_taken, out_valid, cdb_grant;
    logic out_taken, out_mispred;
    logic [31:0] in_pc, in_imm, in_rs1, in_rs2, out_data, out_target;
    logic [5:0]  in_op;
    logic [3:0]  in_tag, out_tag;
    logic [2:0]  count;

    alu_exec_queue #(.XLEN(XLEN), .TAG_W(TAG_W), .OP_W(OP_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_op(in_op),
        .in_imm(in_imm), .in_tag(in_tag), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_pred_taken(in_pred_taken), .out_valid(out_valid), .cdb_grant(cdb_grant),
        .out_tag(out_tag), .out_data(out_data), .out_taken(out_taken),
        .out_target(out_target), .out_mispred(out_mispred), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, imm, rs1, rs2;
        logic [5:0]  op;
        logic [3:0]  tag;
        logic        pred;
    } ent_t;

    typedef struct {
        logic [31:0] data, target;
        logic        taken, mispred;
    } res_t;

    ent_t mq[$];
    logic m_ov;
    logic [3:0] m_tag;
    res_t m_res;
    int n_chk = 0, n_fail = 0;

    function automatic logic slt_s(logic [31:0] a, logic [31:0] b);
        return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    endfunction

    function automatic logic [31:0] sra32(logic [31:0] a, logic [4:0] sh);
        logic [63:0] ext;
        ext = {{32{a[31]}}, a} >> sh;
        return ext[31:0];
    endfunction

    function automatic res_t ref_exec(ent_t e);
        res_t r;
        logic br, c;
        r.data = 0; r.taken = 0; r.target = e.pc + 4; br = 0; c = 0;
        case (e.op)
            LUI:   r.data = e.imm;
            AUIPC: r.data = e.pc + e.imm;
            JAL:   begin r.data = e.pc + 4; r.taken = 1; r.target = e.pc + e.imm; end
            JALR:  begin r.data = e.pc + 4; r.taken = 1; r.target = (e.rs1 + e.imm) & 32'hFFFF_FFFE; end
            BEQ:   begin br = 1; c = (e.rs1 == e.rs2); end
            BNE:   begin br = 1; c = (e.rs1 != e.rs2); end
            BLT:   begin br = 1; c = slt_s(e.rs1, e.rs2); end
            BGE:   begin br = 1; c = !slt_s(e.rs1, e.rs2); end
            BLTU:  begin br = 1; c = (e.rs1 < e.rs2); end
            BGEU:  begin br = 1; c = !(e.rs1 < e.rs2); end
            ADDI:  r.data = e.rs1 + e.imm;
            SLTI:  r.data = {31'd0, slt_s(e.rs1, e.imm)};
            SLTIU: r.data = {31'd0, e.rs1 < e.imm};
            XORI:  r.data = e.rs1 ^ e.imm;
            ORI:   r.data = e.rs1 | e.imm;
            ANDI:  r.data = e.rs1 & e.imm;
            SLLI:  r.data = e.rs1 << e.imm[4:0];
            SRLI:  r.data = e.rs1 >> e.imm[4:0];
            SRAI:  r.data = sra32(e.rs1, e.imm[4:0]);
            ADD:   r.data = e.rs1 + e.rs2;
            SUB:   r.data = e.rs1 + ~e.rs2 + 1;
            SLL:   r.data = e.rs1 << e.rs2[4:0];
            SLT:   r.data = {31'd0, slt_s(e.rs1, e.rs2)};
            SLTU:  r.data = {31'd0, e.rs1 < e.rs2};
            XOR_:  r.data = e.rs1 ^ e.rs2;
            SRL:   r.data = e.rs1 >> e.rs2[4:0];
            SRA:   r.data = sra32(e.rs1, e.rs2[4:0]);
            OR_:   r.data = e.rs1 | e.rs2;
            AND_:  r.data = e.rs1 & e.rs2;
            default: ;
        endcase
        if (br) begin
            r.taken = c;
            if (c) r.target = e.pc + e.imm;
        end
        r.mispred = r.taken ^ e.pred;
        return r;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance the reference model by one edge from the currently driven inputs.
    task automatic model_step();
        ent_t e;
        logic pop, acc;
        if (rst) begin
            mq.delete(); m_ov = 0; m_tag = 0;
            m_res = '{data: 0, target: 0, taken: 0, mispred: 0};
        end else if (rdy) begin
            if (flush) begin
                mq.delete(); m_ov = 0;
            end else begin
                pop = (mq.size() > 0) && (!m_ov || cdb_grant);
                acc = in_valid && (mq.size() < DEPTH);
                if (m_ov && cdb_grant)
                    $display("txn tag=%0d data=%08h taken=%0d target=%08h mispred=%0d",
                             m_tag, m_res.data, m_res.taken, m_res.target, m_res.mispred);
                if (pop) begin
                    e = mq.pop_front();
                    m_res = ref_exec(e); m_tag = e.tag; m_ov = 1;
                end else if (cdb_grant) begin
                    m_ov = 0;
                end
                if (acc) begin
                    e.pc = in_pc; e.imm = in_imm; e.rs1 = in_rs1; e.rs2 = in_rs2;
                    e.op = in_op; e.tag = in_tag; e.pred = in_pred_taken;
                    mq.push_back(e);
                end
            end
        end
    endtask

    task automatic compare();
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("count", 64'(count), 64'(mq.size()));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
        if (m_ov) begin
            chk("out_tag", 64'(out_tag), 64'(m_tag));
            chk("out_data", 64'(out_data), 64'(m_res.data));
            chk("out_taken", 64'(out_taken), 64'(m_res.taken));
            chk("out_target", 64'(out_target), 64'(m_res.target));
            chk("out_mispred", 64'(out_mispred), 64'(m_res.mispred));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic set_op(logic [5:0] op, logic [31:0] pc, logic [31:0] imm,
                          logic [31:0] rs1, logic [31:0] rs2, logic [3:0] tag, logic pred);
        in_op = op; in_pc = pc; in_imm = imm; in_rs1 = rs1; in_rs2 = rs2;
        in_tag = tag; in_pred_taken = pred;
    endtask

    // Issue one op into an empty unit and advance until its result is held.
    task automatic issue(logic [5:0] op, logic [31:0] pc, logic [31:0] imm,
                         logic [31:0] rs1, logic [31:0] rs2, logic [3:0] tag, logic pred);
        set_op(op, pc, imm, rs1, rs2, tag, pred);
        in_valid = 1;
        cycle();
        in_valid = 0;
        cycle();
    endtask

    task automatic drain();
        in_valid = 0; cdb_grant = 1;
        for (int i = 0; i < DEPTH + 2; i++) cycle();
    endtask

    initial begin
        rst = 1; rdy = 1; flush = 0; in_valid = 0; cdb_grant = 0;
        set_op(0, 0, 0, 0, 0, 0, 0);
        m_ov = 0; m_tag = 0; m_res = '{data: 0, target: 0, taken: 0, mispred: 0};
        @(negedge clk);
        cycle(); cycle();
        rst = 0;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_count", 64'(count), 0);
        chk("rst_in_ready", 64'(in_ready), 1);
        chk("rst_out_fields", {out_data, 28'(out_target), out_tag}, 0);
        chk("rst_flags", {out_taken, out_mispred}, 0);

        // ADD with grant tied high: not visible after accept edge, visible after the next
        cdb_grant = 1;
        set_op(ADD, 32'h10, 0, 5, 7, 3, 0);
        in_valid = 1;
        cycle();
        chk("add_lat_accept_edge", 64'(out_valid), 0);
        in_valid = 0;
        cycle();
        chk("add_valid", 64'(out_valid), 1);
        chk("add_data", 64'(out_data), 12);
        chk("add_tag", 64'(out_tag), 3);
        chk("add_taken", 64'(out_taken), 0);
        chk("add_target", 64'(out_target), 32'h14);
        cycle();
        chk("add_one_cycle", 64'(out_valid), 0);

        issue(BLT, 32'h100, 32'h20, 32'hFFFF_FFFF, 1, 4, 0);
        chk("blt_taken", 64'(out_taken), 1);
        chk("blt_target", 64'(out_target), 32'h120);
        chk("blt_mispred", 64'(out_mispred), 1);
        issue(BLTU, 32'h100, 32'h20, 32'hFFFF_FFFF, 1, 5, 0);
        chk("bltu_taken", 64'(out_taken), 0);
        chk("bltu_target", 64'(out_target), 32'h104);
        chk("bltu_mispred", 64'(out_mispred), 0);
        issue(SRA, 32'h0, 0, 32'h8000_0000, 32'h24, 6, 0);
        chk("sra_data", 64'(out_data), 32'hF800_0000);
        issue(JALR, 32'h40, 4, 32'h1001, 0, 7, 1);
        chk("jalr_data", 64'(out_data), 32'h44);
        chk("jalr_target", 64'(out_target), 32'h1004);
        chk("jalr_taken", 64'(out_taken), 1);
        chk("jalr_mispred", 64'(out_mispred), 0);
        issue(6'd31, 32'h200, 0, 1, 2, 8, 1);
        chk("unk_data", 64'(out_data), 0);
        chk("unk_target", 64'(out_target), 32'h204);
        chk("unk_mispred", 64'(out_mispred), 1);
        drain();

        // Backpressure: capacity is queue plus output register
        cdb_grant = 0;
        for (int t = 1; t <= 6; t++) begin
            set_op(ADD, 32'h300, 0, t, 0, 4'(t), 0);
            in_valid = 1;
            cycle();
        end
        in_valid = 0;
        cycle();
        chk("bp_count", 64'(count), 4);
        chk("bp_in_ready", 64'(in_ready), 0);
        chk("bp_tag_held", 64'(out_tag), 1);
        cdb_grant = 1;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            chk("bp_order", 64'(out_tag), 64'(k + 1));
        end
        cycle();
        chk("bp_empty", 64'(out_valid), 0);

        // Flush with pending work and a same-cycle issue
        cdb_grant = 0;
        for (int t = 1; t <= 3; t++) begin
            set_op(ADDI, 32'h400, 1, t, 0, 4'(t), 0);
            in_valid = 1;
            cycle();
        end
        set_op(ADD, 32'h500, 0, 1, 1, 9, 0);
        flush = 1; cdb_grant = 1;
        cycle();
        flush = 0; in_valid = 0;
        chk("flush_valid", 64'(out_valid), 0);
        chk("flush_count", 64'(count), 0);
        chk("flush_ready", 64'(in_ready), 1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("flush_no_emit", 64'(out_valid), 0);
        end

        // Global stall with grant asserted
        cdb_grant = 0;
        for (int t = 4; t <= 5; t++) begin
            set_op(XORI, 32'h600, 32'hF, t, 0, 4'(t), 0);
            in_valid = 1;
            cycle();
        end
        in_valid = 0;
        cycle();
        rdy = 0; cdb_grant = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_tag", 64'(out_tag), 4);
            chk("stall_count", 64'(count), 1);
            chk("stall_valid", 64'(out_valid), 1);
        end
        rdy = 1;
        cycle();
        chk("resume_next_tag", 64'(out_tag), 5);
        drain();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            rdy       = ($urandom_range(0, 9) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 9) < 6);
            cdb_grant = ($urandom_range(0, 9) < 5);
            set_op(6'($urandom_range(0, 31)), $urandom & 32'hFFFF_FFFC,
                   ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom,
                   ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                   ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                   4'($urandom), 1'($urandom));
            cycle();
        end
        rst = 0; rdy = 1; flush = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_exec_queue.md
Name: alu_exec_queue

Overview:
- Parametrised integer execution unit for the out-of-order core; successor to the single-cycle execute stage.
- Takes issued ops from the RS through a valid/ready handshake and buffers them in an in-order DEPTH-entry queue.
- Computes ALU, branch and jump results and holds each result in an output register until the CDB arbiter grants it.
- Resolves branch mispredicts against the predicted direction, and supports flush on pipeline recovery and a global rdy stall.

Parameters:
XLEN, 32, data/address width
TAG_W, 4, ROB nickname (tag) width
OP_W, 6, opcode field width; encodings per the shared opcode definitions (LUI..AND)
DEPTH, 4, input queue entries; power of 2, >=2

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
rdy  in  1  global enable; low = full stall
flush  in  1  discard all queued and held work
in_valid  in  1  RS issue valid
in_ready  out  1  queue can accept
in_pc  in  XLEN  instruction pc
in_op  in  OP_W  opcode
in_imm  in  XLEN  sign-extended immediate
in_tag  in  TAG_W  destination ROB tag
in_rs1  in  XLEN  operand 1
in_rs2  in  XLEN  operand 2
in_pred_taken  in  1  predicted direction
out_valid  out  1  result held for CDB
cdb_grant  in  1  arbiter accepts held result
out_tag  out  TAG_W  result tag
out_data  out  XLEN  rd value
out_taken  out  1  branch/jump taken
out_target  out  XLEN  resolved next pc
out_mispred  out  1  out_taken != predicted
count  out  clog2(DEPTH)+1  queue occupancy

Behaviour:
- Reset:
  - Queue pointers and count are 0; all out_* are 0.
  - in_ready is 1 after reset.
  - rst dominates flush and rdy.
- rdy=0:
  - No state changes: no accept, no pop, and cdb_grant is ignored.
  - All outputs hold their values.
- Input side:
  - in_ready = (count < DEPTH). It does not depend on pop; no same-edge pass-through when full.
  - An op is accepted when in_valid & in_ready & rdy & !flush.
  - The entry stores pc, op, imm, tag, rs1, rs2 and pred_taken.
  - Write pointer wraps mod DEPTH.
- Pop/compute:
  - Fires when count>0 & (!out_valid | cdb_grant) & rdy & !flush.
  - The head entry is evaluated combinationally and loaded into the output registers; out_valid=1.
  - Read pointer wraps mod DEPTH.
- Grant:
  - out_valid & cdb_grant with no pop clears out_valid.
  - Grant with a pop reloads the output register, giving one result per cycle sustained.
- Latency:
  - An op accepted at edge N into an empty unit shows out_valid after edge N+1.
  - Total capacity is DEPTH+1 (queue plus output register).
- Simultaneous push and pop: count unchanged.
- Flush:
  - At the next edge, count=0, pointers=0 and out_valid=0.
  - Same-cycle input and grant are ignored.
- Arithmetic:
  - XLEN-bit, wraps mod 2^XLEN.
  - Shift amount is the low 5 bits (rs2 or imm). SRA/SRAI are arithmetic.
  - SLT/SLTI are signed; SLTU/SLTIU are unsigned. The result is zero-extended 0/1.
- LUI: data = imm.
- AUIPC: data = pc + imm.
- Branches (BEQ/BNE/BLT/BGE/BLTU/BGEU):
  - data = 0.
  - taken per compare.
  - target = taken ? pc+imm : pc+4.
- JAL:
  - data = pc+4, taken = 1.
  - target = pc+imm.
- JALR:
  - data = pc+4, taken = 1.
  - target = (rs1+imm) & ~1.
- ALU ops: taken=0 and target=pc+4.
- out_mispred = out_taken ^ pred_taken for every op; the ROB uses it only for branch and jump entries.
- Unknown opcode:
  - data=0, taken=0, target=pc+4, mispred=pred_taken.
  - Still broadcast so the ROB entry completes.
- Output fields hold stable while out_valid=1 and no grant.

Test Plan:
- ADD, rs1=5, rs2=7, tag=3, grant tied 1 -> out_valid one cycle after the accept edge; data=12, tag=3, taken=0, target=pc+4; valid for 1 cycle.
- BLT, pc=0x100, imm=0x20, rs1=0xFFFFFFFF, rs2=1, pred=0 -> taken=1, target=0x120, mispred=1. Same operands with BLTU -> taken=0, target=0x104, mispred=0.
- grant=0, issue 6 ADDs (tags 1..6), DEPTH=4 -> 5 accepted, in_ready=0, count=4, out tag=1 held stable. Then grant=1 -> tags 1..5 emitted on consecutive cycles, in order.
- 3 ops pending plus a new in_valid in the flush cycle -> next cycle out_valid=0, count=0, in_ready=1; the flush-cycle op is never emitted.
- SRA, rs1=0x80000000, rs2=0x24 -> data=0xF8000000. JALR, pc=0x40, rs1=0x1001, imm=4 -> data=0x44, target=0x1004, taken=1.
- rdy=0 for 3 cycles with out_valid=1 and grant=1 -> outputs and count frozen, no tag consumed. rdy=1 resumes with the same tag first.
